// File: rtl/mux2_stream_arbiter.sv
// -----------------------------------------------------------------------------
// mux2_stream_arbiter
//
// Round-robin arbiter/sequencer in front of the shared 8-bit 2:1 byte mux.
// Grants one of two valid/ready sources at a time. A grant is held for a whole
// packet (until a beat with last = 1) or until MAX_BURST beats have been taken,
// whichever comes first. The chosen byte is registered into a single output
// slot tagged with its source.
//
// Ports
//   clk, areset          clock (rising edge), asynchronous active-high reset
//   a_valid/a_data/a_last/a_ready   source A stream (a_ready is an output)
//   b_valid/b_data/b_last/b_ready   source B stream (b_ready is an output)
//   sel                  registered mux select: 1 = A granted, 0 = B granted
//   out_valid/out_data/out_src      output slot (out_src: 0 = A, 1 = B)
//   out_ready            consumer accepts the slot when out_valid && out_ready
//   busy                 a grant is active or the slot is occupied
// -----------------------------------------------------------------------------
module mux2_stream_arbiter #(
   parameter int WIDTH     = 8,
   parameter int MAX_BURST = 4
) (
   input  logic             clk,
   input  logic             areset,
   input  logic             a_valid,
   input  logic [WIDTH-1:0] a_data,
   input  logic             a_last,
   output logic             a_ready,
   input  logic             b_valid,
   input  logic [WIDTH-1:0] b_data,
   input  logic             b_last,
   output logic             b_ready,
   output logic             sel,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   output logic             out_src,
   input  logic             out_ready,
   output logic             busy
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOCK_A = 2'd1,
      LOCK_B = 2'd2
   } state_t;

   // Last beat index of a grant; release happens on that beat so the 8-bit
   // counter never has to represent MAX_BURST itself.
   localparam logic [7:0] BEAT_CAP = 8'(MAX_BURST - 1);

   state_t             state_q, state_d;
   logic               sel_q, sel_d;
   logic               last_grant_q, last_grant_d;   // 0 = A, 1 = B
   logic [7:0]         beat_cnt_q, beat_cnt_d;
   logic               out_valid_q, out_valid_d;
   logic [WIDTH-1:0]   out_data_q, out_data_d;
   logic               out_src_q, out_src_d;

   logic               slot_free;
   logic               xfer_a, xfer_b, xfer;
   logic               xfer_last;
   logic               xfer_src;
   logic [WIDTH-1:0]   xfer_data;
   logic               grant_release;

   // The slot can take a new beat if it is empty or is being drained this
   // cycle; readies depend only on state and out_ready, never on the valids.
   assign slot_free = !out_valid_q || out_ready;
   assign a_ready   = (state_q == LOCK_A) && slot_free;
   assign b_ready   = (state_q == LOCK_B) && slot_free;

   assign xfer_a    = a_valid && a_ready;
   assign xfer_b    = b_valid && b_ready;
   assign xfer      = xfer_a || xfer_b;
   assign xfer_src  = xfer_b;
   assign xfer_last = xfer_b ? b_last : a_last;
   assign xfer_data = xfer_b ? b_data : a_data;

   assign grant_release = xfer && (xfer_last || (beat_cnt_q == BEAT_CAP));

   // Grant FSM: next state, select, priority pointer and burst counter.
   always_comb begin
      state_d      = state_q;
      sel_d        = sel_q;
      last_grant_d = last_grant_q;
      beat_cnt_d   = beat_cnt_q;
      case (state_q)
         IDLE: begin
            // A wins when alone, or on a tie when B was granted last.
            if (a_valid && (!b_valid || last_grant_q)) begin
               state_d = LOCK_A;
               sel_d   = 1'b1;
            end else if (b_valid) begin
               state_d = LOCK_B;
               sel_d   = 1'b0;
            end
         end
         LOCK_A, LOCK_B: begin
            if (grant_release) begin
               state_d      = IDLE;
               last_grant_d = xfer_src;
               beat_cnt_d   = 8'd0;
            end else if (xfer) begin
               beat_cnt_d = beat_cnt_q + 8'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Output slot: a transfer overwrites the slot (covering a same-cycle
   // consume), otherwise a consume simply empties it. Data/src hold.
   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_src_d   = out_src_q;
      if (xfer) begin
         out_valid_d = 1'b1;
         out_data_d  = xfer_data;
         out_src_d   = xfer_src;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         state_q      <= IDLE;
         sel_q        <= 1'b0;
         last_grant_q <= 1'b1;
         beat_cnt_q   <= 8'd0;
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
         out_src_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         sel_q        <= sel_d;
         last_grant_q <= last_grant_d;
         beat_cnt_q   <= beat_cnt_d;
         out_valid_q  <= out_valid_d;
         out_data_q   <= out_data_d;
         out_src_q    <= out_src_d;
      end
   end

   assign sel       = sel_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_src   = out_src_q;
   assign busy      = (state_q != IDLE) || out_valid_q;

endmodule
